// File: rtl/rr_arb8.sv
// rr_arb8: round-robin arbiter for an 8-way decoded resource with break-before-make and an optional hold limit
module rr_arb8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] gnt_idx,
    output logic       gnt_en,
    output logic [7:0] gnt_oh,
    output logic       preempt
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
    state_t state, state_n;
    logic [2:0] ptr, ptr_n, idx_n, win;
    logic [7:0] oh_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic en_n, pre_n, limit;
    assign limit = (MAX_HOLD != 0) && (cnt == LAST);
    // descending scan so the lowest offset from ptr wins
    always_comb begin
        win = ptr;
        for (int k = 7; k >= 0; k--)
            if (req[ptr + 3'(k)]) win = ptr + 3'(k);
    end
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        en_n    = gnt_en;
        oh_n    = gnt_oh;
        cnt_n   = cnt;
        pre_n   = 1'b0;
        if (state == IDLE) begin
            if (|req) begin
                state_n = GRANT;
                idx_n   = win;
                en_n    = 1'b1;
                oh_n    = 8'h80 >> win;
                cnt_n   = '0;
            end
        end else if (!req[gnt_idx] || limit) begin
            // a voluntary drop takes precedence, so preempt only flags a still-requesting owner
            state_n = IDLE;
            en_n    = 1'b0;
            oh_n    = 8'h00;
            ptr_n   = gnt_idx + 3'd1;
            pre_n   = req[gnt_idx];
        end else begin
            cnt_n = &cnt ? cnt : cnt + CNT_W'(1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            gnt_en  <= 1'b0;
            gnt_oh  <= '0;
            cnt     <= '0;
            preempt <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt_idx <= idx_n;
            gnt_en  <= en_n;
            gnt_oh  <= oh_n;
            cnt     <= cnt_n;
            preempt <= pre_n;
        end
    end
endmodule
